alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response bundle of alu_arbiter.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic              req0_valid;
   logic              req1_valid;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [OP_W-1:0]   req0_aluc;
   logic [OP_W-1:0]   req1_aluc;
   logic              req0_ready;
   logic              req1_ready;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_aluc;
   logic [DATA_W-1:0] alu_r;
   logic              alu_zero;
   logic              alu_carry;
   logic              alu_negative;
   logic              alu_overflow;
   logic              rsp_valid;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_r;
   logic [3:0]        rsp_flags;
   logic              rsp_ready;

   modport slave (
      input  req0_valid, req1_valid,
      input  req0_a, req0_b, req1_a, req1_b,
      input  req0_aluc, req1_aluc,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_aluc,
      input  alu_r, alu_zero, alu_carry,
      input  alu_negative, alu_overflow,
      output rsp_valid, rsp_id, rsp_r, rsp_flags,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req1_valid,
      output req0_a, req0_b, req1_a, req1_b,
      output req0_aluc, req1_aluc,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_aluc,
      output alu_r, alu_zero, alu_carry,
      output alu_negative, alu_overflow,
      input  rsp_valid, rsp_id, rsp_r, rsp_flags,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// ALU_ARBITER_RR_EN selects round-robin; otherwise req0 has fixed priority.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_aluc_q, alu_aluc_d;
   logic              gnt_id_q, gnt_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_r_q, rsp_r_d;
   logic [3:0]        rsp_flags_q, rsp_flags_d;

   logic open_win;
   logic gnt1;
   logic ready0;
   logic ready1;
   logic accept;

`ifdef ALU_ARBITER_RR_EN
   logic last_q, last_d;

   // last_q=0 means req0 was granted last, so req1 wins a tie
   always_comb begin
      gnt1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
      last_d = last_q;
      if (accept) begin
         last_d = gnt1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      gnt1 = bus.req1_valid & ~bus.req0_valid;
   end
`endif

   always_comb begin
      open_win = ~rst & ((state_q == IDLE) |
                 ((state_q == RESP) & bus.rsp_ready));
      ready0   = open_win & bus.req0_valid & ~gnt1;
      ready1   = open_win & gnt1;
      accept   = ready0 | ready1;
   end

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_aluc_d  = alu_aluc_q;
      gnt_id_d    = gnt_id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_r_d     = rsp_r_q;
      rsp_flags_d = rsp_flags_q;

      if (accept) begin
         alu_a_d    = gnt1 ? bus.req1_a : bus.req0_a;
         alu_b_d    = gnt1 ? bus.req1_b : bus.req0_b;
         alu_aluc_d = gnt1 ? bus.req1_aluc : bus.req0_aluc;
         gnt_id_d   = gnt1;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_r_d     = bus.alu_r;
            rsp_flags_d = {bus.alu_zero, bus.alu_carry,
                           bus.alu_negative, bus.alu_overflow};
            rsp_id_d    = gnt_id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = accept ? EXEC : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_aluc_q  <= '0;
         gnt_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_r_q     <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_aluc_q  <= alu_aluc_d;
         gnt_id_q    <= gnt_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_r_q     <= rsp_r_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_aluc   = alu_aluc_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_r      = rsp_r_q;
   assign bus.rsp_flags  = rsp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an ALU model and response scoreboard.
module tb_alu_arbiter;
   typedef struct {
      logic        id;
      logic [31:0] r;
      logic [3:0]  f;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];
   logic gq[$];
   logic prev_v = 1'b0;

   alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

   alu_arbiter #(.DATA_W(32), .OP_W(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ops: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR
   function automatic logic [35:0] alu_fn(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0] op);
      logic [32:0] w;
      logic [31:0] r;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      w = '0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         default: r = '0;
      endcase
      return {r, (r == 32'd0), c, r[31], v};
   endfunction

   always_comb begin
      {bus.alu_r, bus.alu_zero, bus.alu_carry,
       bus.alu_negative, bus.alu_overflow} =
         alu_fn(bus.alu_a, bus.alu_b, bus.alu_aluc);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [35:0] res;
      exp_t        e;
      if (rst) begin
         sb.delete();
         prev_v = 1'b0;
      end else begin
         chk("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
         if (bus.req0_valid && bus.req0_ready) begin
            res = alu_fn(bus.req0_a, bus.req0_b, bus.req0_aluc);
            sb.push_back('{1'b0, res[35:4], res[3:0], cyc});
            gq.push_back(1'b0);
         end
         if (bus.req1_valid && bus.req1_ready) begin
            res = alu_fn(bus.req1_a, bus.req1_b, bus.req1_aluc);
            sb.push_back('{1'b1, res[35:4], res[3:0], cyc});
            gq.push_back(1'b1);
         end
         if (bus.rsp_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_rsp", 1, 0);
            end else begin
               chk("latency", cyc - sb[0].cyc, 2);
            end
         end
         if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_id", bus.rsp_id, e.id);
            chk("sb_r", bus.rsp_r, e.r);
            chk("sb_flags", bus.rsp_flags, e.f);
         end
         prev_v = bus.rsp_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic do_op(input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        output logic [31:0] r, output logic [3:0] f,
                        output logic rid);
      bit ok;
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_aluc = op;
         bus.req1_valid = 1'b1;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_aluc = op;
         bus.req0_valid = 1'b1;
      end
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) begin
            ok = 1;
            break;
         end
      end
      chk("op_accept", ok, 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1;
            break;
         end
      end
      chk("op_rsp", ok, 1);
      r   = bus.rsp_r;
      f   = bus.rsp_flags;
      rid = bus.rsp_id;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] r, sr;
      logic [3:0]  f, sf;
      logic        rid, sid;
      logic        exp_g[4];
      int          n1;

      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.req0_a = 32'h11; bus.req0_b = 32'h22; bus.req0_aluc = 4'd0;
      bus.req1_a = 32'h33; bus.req1_b = 32'h44; bus.req1_aluc = 4'd0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_r", bus.rsp_r, 0);
      chk("rst_rsp_flags", bus.rsp_flags, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_aluc", bus.alu_aluc, 0);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // single ADD with cycle-exact timing
      bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_aluc = 4'd0;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      chk("single_ready0", bus.req0_ready, 1);
      chk("single_ready1", bus.req1_ready, 0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("single_exec_nv", bus.rsp_valid, 0);
      chk("single_alu_a", bus.alu_a, 5);
      chk("single_alu_b", bus.alu_b, 3);
      chk("single_alu_aluc", bus.alu_aluc, 0);
      @(negedge clk);
      chk("single_rsp_valid", bus.rsp_valid, 1);
      chk("single_rsp_id", bus.rsp_id, 0);
      chk("single_rsp_r", bus.rsp_r, 8);
      chk("single_rsp_flags", bus.rsp_flags, 4'b0000);
      @(negedge clk);
      chk("single_idle", bus.rsp_valid, 0);

      // flags
      do_op(1'b0, 32'h8000_0000, 32'd1, 4'd1, r, f, rid);
      chk("ovf_r", r, 32'h7FFF_FFFF);
      chk("ovf_flags", f, 4'b0001);
      do_op(1'b1, 32'd7, 32'd7, 4'd1, r, f, rid);
      chk("zero_r", r, 0);
      chk("zero_flags", f, 4'b1000);
      chk("zero_id", rid, 1);

      // opaque op code, then operands held while idle
      do_op(1'b0, 32'hA5, 32'h5A, 4'hF, r, f, rid);
      chk("opF_r", r, 0);
      repeat (3) @(negedge clk);
      chk("hold_alu_a", bus.alu_a, 32'hA5);
      chk("hold_alu_b", bus.alu_b, 32'h5A);
      chk("hold_alu_aluc", bus.alu_aluc, 4'hF);

      // reset while in EXEC after a req0 grant
      @(posedge clk); #1;
      bus.req0_a = 32'd9; bus.req0_b = 32'd1; bus.req0_aluc = 4'd0;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      chk("rstop_accept", bus.req0_ready, 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstop_ready_low", bus.req1_ready | bus.req0_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstop_no_rsp", bus.rsp_valid, 0);
      end
      chk("rstop_alu_a", bus.alu_a, 0);
      chk("rstop_rsp_r", bus.rsp_r, 0);
      chk("rstop_sb_empty", sb.size(), 0);

      // contention
`ifdef ALU_ARBITER_RR_EN
      exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`else
      exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`endif
      @(posedge clk); #1;
      gq.delete();
      bus.rsp_ready = 1'b1;
      bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_aluc = 4'd0;
      bus.req1_a = 32'd10; bus.req1_b = 32'd20; bus.req1_aluc = 4'd3;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (gq.size() >= 4) break;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      chk("cont_count", gq.size() >= 4, 1);
      for (int i = 0; i < 4; i++) begin
         if (i < gq.size()) chk("cont_order", gq[i], exp_g[i]);
      end
      repeat (4) @(posedge clk);
      #1;

      // backpressure
      bus.rsp_ready = 1'b0;
      bus.req0_a = 32'hF0; bus.req0_b = 32'h3C; bus.req0_aluc = 4'd2;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      chk("bp_accept", bus.req0_ready, 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_aluc = 4'd3;
      bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("bp_exec_ready1", bus.req1_ready, 0);
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_r", bus.rsp_r, 32'h30);
      sr = bus.rsp_r; sf = bus.rsp_flags; sid = bus.rsp_id;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", bus.rsp_valid, 1);
         chk("bp_hold_r", bus.rsp_r, sr);
         chk("bp_hold_f", bus.rsp_flags, sf);
         chk("bp_hold_id", bus.rsp_id, sid);
         chk("bp_ready_low", bus.req0_ready | bus.req1_ready, 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready1", bus.req1_ready, 1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("bp_exec_nv", bus.rsp_valid, 0);
      @(negedge clk);
      chk("bp_next_valid", bus.rsp_valid, 1);
      chk("bp_next_id", bus.rsp_id, 1);
      chk("bp_next_r", bus.rsp_r, 3);
      @(posedge clk); #1;

      // withdrawn valid during EXEC
      gq.delete();
      bus.req0_a = 32'd4; bus.req0_b = 32'd4; bus.req0_aluc = 4'd4;
      bus.req0_valid = 1'b1;
      @(negedge clk);
      chk("wd_accept", bus.req0_ready, 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("wd_exec_ready1", bus.req1_ready, 0);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n1 = 0;
      foreach (gq[i]) if (gq[i]) n1++;
      chk("wd_no_grant1", n1, 0);
      chk("wd_grants", gq.size(), 1);
      chk("final_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
